bsnn_stream_sink: RTL and testbench

Consumer-side endpoint for the BSNN streaming accelerator's output stream (valid/ready + output_spikes). It snoops the accelerator's input handshake to timestamp and tag every accepted input row in an in-order tag FIFO. It accepts output beats with backpressure, pairs each with its tag, computes end-to-end latency and spike popcount, and emits one result record per beat. It is the hardware replacement for bench-side latency bookkeeping and sits between the accelerator output and the result/logging path.

---
 rtl/bsnn_stream_sink.sv | 134 +++++++++++++
 tb/tb_bsnn_stream_sink.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsnn_stream_sink.sv
// Output-stream endpoint for the BSNN accelerator: tags snooped input rows, pairs them with output beats,
// and emits {id, latency, popcount, spikes} records. Define BSNN_SINK_THROTTLE_EN for LFSR stall injection.
module bsnn_stream_sink #(
  parameter int N_NEURONS = 256,
  parameter int TAG_DEPTH = 32,
  parameter int ID_WIDTH  = 16,
  parameter int TS_WIDTH  = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               snoop_valid_in,
  input  logic                               snoop_ready_in,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [N_NEURONS-1:0]               s_spikes,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [ID_WIDTH-1:0]                m_id,
  output logic [TS_WIDTH-1:0]                m_latency,
  output logic [$clog2(N_NEURONS+1)-1:0]     m_popcount,
  output logic [N_NEURONS-1:0]               m_spikes,
  output logic [$clog2(TAG_DEPTH+1)-1:0]     inflight_count,
  output logic                               overflow_err,
  output logic                               underflow_err,
  output logic [TS_WIDTH-1:0]                cycle_count
);

  localparam int PW   = $clog2(TAG_DEPTH);
  localparam int CW   = $clog2(TAG_DEPTH+1);
  localparam int POPW = $clog2(N_NEURONS+1);

  function automatic logic [POPW-1:0] popcount(input logic [N_NEURONS-1:0] v);
    logic [POPW-1:0] c;
    c = {POPW{1'b0}};
    for (int i = 0; i < N_NEURONS; i++) c = c + POPW'(v[i]);
    return c;
  endfunction

  logic [ID_WIDTH-1:0] id_mem [TAG_DEPTH];
  logic [TS_WIDTH-1:0] ts_mem [TAG_DEPTH];
  logic [ID_WIDTH-1:0] seq_id;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic                push;
  logic                push_ok;
  logic                pop;
  logic                accept;
  logic                has_tag;
  logic                full;
  logic                stall;

`ifdef BSNN_SINK_THROTTLE_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR (taps 16,14,13,11) driving deterministic stall injection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign s_ready = !rst && (!m_valid || m_ready) && !stall;
  assign accept  = s_valid && s_ready;
  assign push    = snoop_valid_in && snoop_ready_in;
  assign has_tag = (inflight_count != {CW{1'b0}});
  assign full    = (inflight_count == CW'(TAG_DEPTH));
  assign pop     = accept && has_tag;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push
  assign push_ok = push && (!full || pop);

  // Tag storage; head is read combinationally before any same-cycle overwrite
  always_ff @(posedge clk) begin
    if (push_ok) begin
      id_mem[wr_ptr] <= seq_id;
      ts_mem[wr_ptr] <= cycle_count;
    end else begin
      id_mem[wr_ptr] <= id_mem[wr_ptr];
    end
  end

  // Counters, FIFO bookkeeping, sticky errors and the single result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count    <= {TS_WIDTH{1'b0}};
      seq_id         <= {ID_WIDTH{1'b0}};
      wr_ptr         <= {PW{1'b0}};
      rd_ptr         <= {PW{1'b0}};
      inflight_count <= {CW{1'b0}};
      overflow_err   <= 1'b0;
      underflow_err  <= 1'b0;
      m_valid        <= 1'b0;
      m_id           <= {ID_WIDTH{1'b0}};
      m_latency      <= {TS_WIDTH{1'b0}};
      m_popcount     <= {POPW{1'b0}};
      m_spikes       <= {N_NEURONS{1'b0}};
    end else begin
      cycle_count <= cycle_count + TS_WIDTH'(1);
      if (push)             seq_id        <= seq_id + ID_WIDTH'(1);
      if (push_ok)          wr_ptr        <= wr_ptr + PW'(1);
      if (pop)              rd_ptr        <= rd_ptr + PW'(1);
      if (push && !push_ok) overflow_err  <= 1'b1;
      if (accept && !has_tag) underflow_err <= 1'b1;
      case ({push_ok, pop})
        2'b10:   inflight_count <= inflight_count + CW'(1);
        2'b01:   inflight_count <= inflight_count - CW'(1);
        default: inflight_count <= inflight_count;
      endcase
      if (accept) begin
        m_valid    <= 1'b1;
        m_spikes   <= s_spikes;
        m_popcount <= popcount(s_spikes);
        if (has_tag) begin
          m_id      <= id_mem[rd_ptr];
          m_latency <= cycle_count - ts_mem[rd_ptr];
        end else begin
          m_id      <= {ID_WIDTH{1'b1}};
          m_latency <= {TS_WIDTH{1'b0}};
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end else begin
        m_valid <= m_valid;
      end
    end
  end

endmodule

// File: tb/tb_bsnn_stream_sink.sv
// Randomized + directed bench for bsnn_stream_sink against a queue-based tag/latency model.
module tb_bsnn_stream_sink;
  localparam int N  = 256;
  localparam int D  = 32;
  localparam int IW = 16;
  localparam int TW = 32;
  localparam int CW = $clog2(D+1);
  localparam int PW = $clog2(N+1);

  logic clk = 1'b0;
  logic rst;
  logic snoop_valid_in, snoop_ready_in, s_valid, s_ready, m_valid, m_ready;
  logic [N-1:0]  s_spikes, m_spikes;
  logic [IW-1:0] m_id;
  logic [TW-1:0] m_latency, cycle_count;
  logic [PW-1:0] m_popcount;
  logic [CW-1:0] inflight_count;
  logic overflow_err, underflow_err;

  bsnn_stream_sink dut (
    .clk(clk), .rst(rst),
    .snoop_valid_in(snoop_valid_in), .snoop_ready_in(snoop_ready_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_spikes(s_spikes),
    .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id), .m_latency(m_latency),
    .m_popcount(m_popcount), .m_spikes(m_spikes), .inflight_count(inflight_count),
    .overflow_err(overflow_err), .underflow_err(underflow_err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [IW+TW-1:0] q[$];
  logic [IW-1:0] mseq;
  logic [TW-1:0] mcyc;
  logic          ev, eovf, eunf;
  logic [IW-1:0] eid;
  logic [TW-1:0] elat;
  logic [N-1:0]  espk;
  logic          obs_sready, exp_sready;
  logic [N-1:0]  zero_spk;
  logic [N-1:0]  spk_f;

  task automatic model_reset();
    q.delete();
    mseq = 16'd0; mcyc = 32'd0;
    ev = 1'b0; eovf = 1'b0; eunf = 1'b0;
    eid = 16'd0; elat = 32'd0; espk = '0;
  endtask

  task automatic apply_reset();
    s_valid = 1'b0; s_spikes = '0; snoop_valid_in = 1'b0; snoop_ready_in = 1'b0; m_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [N-1:0] rand_spikes();
    logic [N-1:0] v;
    for (int i = 0; i < N/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock: drive at negedge, advance model by the handshake rules, land on next negedge.
  task automatic step(input logic sv, input logic [N-1:0] spk, input logic snv,
                      input logic snr, input logic mr);
    logic acc;
    logic [IW+TW-1:0] t;
    int sz;
    s_valid = sv; s_spikes = spk; snoop_valid_in = snv; snoop_ready_in = snr; m_ready = mr;
    #1;
    obs_sready = s_ready;
    exp_sready = !ev || mr;
    acc = sv && exp_sready;
    sz = q.size();
    if (acc) begin
      if (sz > 0) begin
        t = q.pop_front();
        eid = t[IW+TW-1:TW];
        elat = mcyc - t[TW-1:0];
      end else begin
        eid = 16'hFFFF; elat = 32'd0; eunf = 1'b1;
      end
      espk = spk; ev = 1'b1;
    end else if (mr) begin
      ev = 1'b0;
    end
    if (snv && snr) begin
      if (q.size() < D) q.push_back({mseq, mcyc});
      else eovf = 1'b1;
      mseq = mseq + 16'd1;
    end
    mcyc = mcyc + 32'd1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    s_valid = 1'b0; s_spikes = '0; snoop_valid_in = 1'b0; snoop_ready_in = 1'b0; m_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_sready got %0b exp 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got %0b exp 0", m_valid); end
    checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_cycle got %0d exp 0", cycle_count); end
    checks++; if (inflight_count !== '0) begin errors++; $display("FAIL rst_count got %0d exp 0", inflight_count); end
    checks++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("FAIL rst_errs got %b exp 00", {overflow_err, underflow_err}); end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, zero_spk, 1'b0, 1'b0, 1'b1);
    checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL cycle_run got %0d exp 3", cycle_count); end
  endtask

  task automatic test_single_row();
    apply_reset();
    while (mcyc != 32'd10) step(1'b0, zero_spk, 1'b0, 1'b0, 1'b1);
    step(1'b0, zero_spk, 1'b1, 1'b1, 1'b1);
    checks++; if (inflight_count !== 6'd1) begin errors++; $display("FAIL single_cnt1 got %0d exp 1", inflight_count); end
    while (mcyc != 32'd34) step(1'b0, zero_spk, 1'b0, 1'b0, 1'b1);
    step(1'b1, spk_f, 1'b0, 1'b0, 1'b1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", m_valid); end
    checks++; if (m_id !== 16'd0) begin errors++; $display("FAIL single_id got %0d exp 0", m_id); end
    checks++; if (m_latency !== 32'd24) begin errors++; $display("FAIL single_lat got %0d exp 24", m_latency); end
    checks++; if (m_popcount !== 9'd4) begin errors++; $display("FAIL single_pop got %0d exp 4", m_popcount); end
    checks++; if (inflight_count !== 6'd0) begin errors++; $display("FAIL single_cnt0 got %0d exp 0", inflight_count); end
  endtask

  task automatic test_stream();
    logic [IW-1:0] base;
    logic [N-1:0] spk;
    apply_reset();
    base = mseq;
    for (int i = 0; i < 8; i++) step(1'b0, zero_spk, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, zero_spk, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      spk = rand_spikes();
      step(1'b1, spk, 1'b0, 1'b0, 1'b1);
      checks++; if (obs_sready !== 1'b1) begin errors++; $display("FAIL stream_sready[%0d] got %0b exp 1", i, obs_sready); end
      checks++; if (m_id !== base + IW'(i)) begin errors++; $display("FAIL stream_id[%0d] got %0d exp %0d", i, m_id, base + IW'(i)); end
      checks++; if (m_latency !== 32'd11) begin errors++; $display("FAIL stream_lat[%0d] got %0d exp 11", i, m_latency); end
      checks++; if (m_popcount !== PW'($countones(spk))) begin errors++; $display("FAIL stream_pop[%0d] got %0d exp %0d", i, m_popcount, $countones(spk)); end
    end
    checks++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("FAIL stream_errs got %b exp 00", {overflow_err, underflow_err}); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] s1, s2;
    s1 = rand_spikes(); s2 = rand_spikes();
    step(1'b0, zero_spk, 1'b1, 1'b1, 1'b1);
    step(1'b0, zero_spk, 1'b1, 1'b1, 1'b1);
    step(1'b1, s1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, s2, 1'b0, 1'b0, 1'b0);
      checks++; if (obs_sready !== 1'b0) begin errors++; $display("FAIL bp_sready[%0d] got %0b exp 0", i, obs_sready); end
      checks++; if ({m_valid, m_id, m_latency} !== {1'b1, eid, elat}) begin errors++; $display("FAIL bp_hold[%0d] got %0h exp %0h", i, {m_valid, m_id, m_latency}, {1'b1, eid, elat}); end
      checks++; if (m_spikes !== s1) begin errors++; $display("FAIL bp_spikes[%0d] got %h exp %h", i, m_spikes, s1); end
    end
    step(1'b1, s2, 1'b0, 1'b0, 1'b1);
    checks++; if (obs_sready !== 1'b1) begin errors++; $display("FAIL bp_release got %0b exp 1", obs_sready); end
    checks++; if ({m_valid, m_id, m_spikes} !== {1'b1, eid, s2}) begin errors++; $display("FAIL bp_next got %0h exp %0h", m_id, eid); end
    checks++; if (inflight_count !== 6'd0) begin errors++; $display("FAIL bp_cnt got %0d exp 0", inflight_count); end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 33; i++) step(1'b0, zero_spk, 1'b1, 1'b1, 1'b1);
    checks++; if (inflight_count !== 6'd32) begin errors++; $display("FAIL ovf_cnt got %0d exp 32", inflight_count); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_err got %0b exp 1", overflow_err); end
    for (int i = 0; i < 32; i++) begin
      step(1'b1, rand_spikes(), 1'b0, 1'b0, 1'b1);
      checks++; if (m_id !== 16'(i)) begin errors++; $display("FAIL ovf_id[%0d] got %0d exp %0d", i, m_id, i); end
    end
    checks++; if (inflight_count !== 6'd0) begin errors++; $display("FAIL ovf_drain got %0d exp 0", inflight_count); end
  endtask

  task automatic test_underflow();
    step(1'b1, spk_f, 1'b1, 1'b1, 1'b1);
    checks++; if (m_id !== 16'hFFFF) begin errors++; $display("FAIL unf_id got %0h exp ffff", m_id); end
    checks++; if (m_latency !== 32'd0) begin errors++; $display("FAIL unf_lat got %0d exp 0", m_latency); end
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL unf_err got %0b exp 1", underflow_err); end
    checks++; if (inflight_count !== 6'd1) begin errors++; $display("FAIL unf_push got %0d exp 1", inflight_count); end
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL sticky_ovf got %0b exp 1", overflow_err); end
    for (int i = 0; i < 31; i++) step(1'b0, zero_spk, 1'b1, 1'b1, 1'b1);
    checks++; if (inflight_count !== 6'd32) begin errors++; $display("FAIL full_cnt got %0d exp 32", inflight_count); end
    step(1'b1, rand_spikes(), 1'b1, 1'b1, 1'b1);
    checks++; if (inflight_count !== 6'd32) begin errors++; $display("FAIL fullpp_cnt got %0d exp 32", inflight_count); end
    checks++; if (m_id !== eid) begin errors++; $display("FAIL fullpp_id got %0d exp %0d", m_id, eid); end
  endtask

  task automatic test_random();
    logic sv, snv, snr, mr;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      sv = ($urandom_range(0, 1) == 1);
      snv = ($urandom_range(0, 1) == 1);
      snr = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 3) != 0);
      step(sv, rand_spikes(), snv, snr, mr);
      checks++; if (obs_sready !== exp_sready) begin errors++; $display("FAIL rnd_sready@%0d got %0b exp %0b", c, obs_sready, exp_sready); end
      checks++; if (m_valid !== ev) begin errors++; $display("FAIL rnd_valid@%0d got %0b exp %0b", c, m_valid, ev); end
      if (ev) begin
        checks++;
        if ({m_id, m_latency, m_popcount} !== {eid, elat, PW'($countones(espk))} || m_spikes !== espk) begin
          errors++; $display("FAIL rnd_rec@%0d got id %0h lat %0d pop %0d exp id %0h lat %0d pop %0d",
                             c, m_id, m_latency, m_popcount, eid, elat, $countones(espk));
        end
      end
      checks++; if (inflight_count !== CW'(q.size())) begin errors++; $display("FAIL rnd_cnt@%0d got %0d exp %0d", c, inflight_count, q.size()); end
      checks++; if ({overflow_err, underflow_err} !== {eovf, eunf}) begin errors++; $display("FAIL rnd_errs@%0d got %b exp %b", c, {overflow_err, underflow_err}, {eovf, eunf}); end
      checks++; if (cycle_count !== mcyc) begin errors++; $display("FAIL rnd_cycle@%0d got %0d exp %0d", c, cycle_count, mcyc); end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    force dut.cycle_count = 32'hFFFF_FFFD;
    step(1'b0, zero_spk, 1'b0, 1'b0, 1'b1);
    release dut.cycle_count;
    step(1'b0, zero_spk, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, zero_spk, 1'b0, 1'b0, 1'b1);
    step(1'b1, spk_f, 1'b0, 1'b0, 1'b1);
    checks++; if (m_latency !== 32'd5) begin errors++; $display("FAIL wrap_lat got %0d exp 5", m_latency); end
    checks++; if (cycle_count >= 32'd16) begin errors++; $display("FAIL wrap_cycle got %0h exp below 10", cycle_count); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b0, zero_spk, 1'b1, 1'b1, 1'b1);
    step(1'b1, rand_spikes(), 1'b0, 1'b0, 1'b1);
    step(1'b1, rand_spikes(), 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b exp 0", m_valid); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_sready got %0b exp 0", s_ready); end
    checks++; if (inflight_count !== 6'd0) begin errors++; $display("FAIL mid_cnt got %0d exp 0", inflight_count); end
    checks++; if (m_id !== 16'd0) begin errors++; $display("FAIL mid_id got %0d exp 0", m_id); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b1, spk_f, 1'b1, 1'b1, 1'b1);
    checks++; if (m_id !== 16'hFFFF) begin errors++; $display("FAIL mid_discard got %0h exp ffff", m_id); end
    checks++; if (inflight_count !== 6'd1) begin errors++; $display("FAIL mid_push got %0d exp 1", inflight_count); end
  endtask

  initial begin
    zero_spk = '0;
    spk_f = '0;
    spk_f[3:0] = 4'hF;
    model_reset();
    test_reset();
    test_single_row();
    test_stream();
    test_backpressure();
    test_overflow();
    test_underflow();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
